// File: rtl/reload_timer.sv
// Auto-reload interval timer: loadable up-counter with reload register, terminal-count pulse and latched interrupt.
// Optional one-shot mode enabled by defining TIMER_ONESHOT_EN (adds the ONESHOT input).
module reload_timer #(
  parameter int WIDTH = 16
) (
  input  logic             MasterClock,
  input  logic             RESET,
  input  logic [WIDTH-1:0] D,
  input  logic             WR,
  input  logic             START,
  input  logic             STOP,
  input  logic             TICK,
  input  logic             ACK,
`ifdef TIMER_ONESHOT_EN
  input  logic             ONESHOT,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             RUN,
  output logic             INT
);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] rld_q;
  logic             tc_q;
  logic             int_q;

  logic             start_go;
  logic             at_top;
  logic             wrap;
  logic             oneshot_sel;
  logic [WIDTH-1:0] load_val;

  // STOP beats START; a START in COUNT restarts and swallows any tick in that cycle.
  assign start_go = START & ~STOP;
  assign at_top   = (q_q == {WIDTH{1'b1}});
  assign wrap     = (state_q == COUNT) & TICK & at_top & ~start_go;
  assign load_val = WR ? D : rld_q;

`ifdef TIMER_ONESHOT_EN
  assign oneshot_sel = ONESHOT;
`else
  assign oneshot_sel = 1'b0;
`endif

  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      state_q <= IDLE;
      q_q     <= '0;
      rld_q   <= '0;
      tc_q    <= 1'b0;
      int_q   <= 1'b0;
    end else begin
      if (WR) rld_q <= D;
      tc_q <= wrap;
      // A wrap wins over a coincident ACK so no interrupt is lost.
      if (wrap)     int_q <= 1'b1;
      else if (ACK) int_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_go) begin
            state_q <= COUNT;
            q_q     <= load_val;
          end else if (WR) begin
            q_q <= D;
          end
        end
        COUNT: begin
          // A wrap reloads the old RLD even when WR lands on the same edge.
          if (start_go)             q_q <= load_val;
          else if (wrap)            q_q <= rld_q;
          else if (TICK && !STOP)   q_q <= q_q + ONE;
          if (STOP || (wrap && oneshot_sel)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Q   = q_q;
  assign TC  = tc_q;
  assign RUN = (state_q == COUNT);
  assign INT = int_q;

endmodule

// File: tb/tb_reload_timer.sv
// Directed bench for reload_timer at WIDTH=4 with hand-computed expectations.
module tb_reload_timer;
  localparam int W = 4;

  logic         MasterClock = 1'b0;
  logic         RESET, WR, START, STOP, TICK, ACK;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         TC, RUN, INT;
`ifdef TIMER_ONESHOT_EN
  logic         ONESHOT;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  reload_timer #(.WIDTH(W)) dut (
    .MasterClock(MasterClock),
    .RESET(RESET),
    .D(D),
    .WR(WR),
    .START(START),
    .STOP(STOP),
    .TICK(TICK),
    .ACK(ACK),
`ifdef TIMER_ONESHOT_EN
    .ONESHOT(ONESHOT),
`endif
    .Q(Q),
    .TC(TC),
    .RUN(RUN),
    .INT(INT)
  );

  always #5 MasterClock = ~MasterClock;

  task automatic clk1();
    @(posedge MasterClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_miss++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] eq, input logic erun,
                         input logic etc, input logic eint);
    chk({tag, ".Q"},   {28'd0, Q}, {28'd0, eq});
    chk({tag, ".RUN"}, {31'd0, RUN}, {31'd0, erun});
    chk({tag, ".TC"},  {31'd0, TC},  {31'd0, etc});
    chk({tag, ".INT"}, {31'd0, INT}, {31'd0, eint});
  endtask

  initial begin
    logic [W-1:0] gq [6];
    logic         gtc[6];
    gq  = '{4'd14, 4'd14, 4'd15, 4'd15, 4'd15, 4'd14};
    gtc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    RESET = 1'b1; WR = 1'b0; START = 1'b0; STOP = 1'b0; TICK = 1'b0; ACK = 1'b0; D = '0;
`ifdef TIMER_ONESHOT_EN
    ONESHOT = 1'b0;
`endif
    clk1();
    RESET = 1'b0;
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-count
    WR = 1'b1; D = 4'd5; clk1(); WR = 1'b0;
    chk("idle_wr.Q", {28'd0, Q}, 32'd5);
    START = 1'b1; clk1(); START = 1'b0;
    chk_all("start5", 4'd5, 1'b1, 1'b0, 1'b0);
    TICK = 1'b1; clk1(); clk1();
    chk("count7.Q", {28'd0, Q}, 32'd7);
    RESET = 1'b1; clk1(); RESET = 1'b0; TICK = 1'b0;
    chk_all("midreset", 4'd0, 1'b0, 1'b0, 1'b0);

    // Periodic wrap with RLD=12
    WR = 1'b1; D = 4'd12; clk1(); WR = 1'b0;
    START = 1'b1; clk1(); START = 1'b0;
    chk_all("start12", 4'd12, 1'b1, 1'b0, 1'b0);
    TICK = 1'b1;
    clk1(); chk("p13.Q", {28'd0, Q}, 32'd13);
    clk1(); chk("p14.Q", {28'd0, Q}, 32'd14);
    clk1(); chk_all("p15", 4'd15, 1'b1, 1'b0, 1'b0);
    clk1(); chk_all("wrap1", 4'd12, 1'b1, 1'b1, 1'b1);
    clk1(); chk_all("after_wrap1", 4'd13, 1'b1, 1'b0, 1'b1);
    ACK = 1'b1; clk1(); ACK = 1'b0;
    chk_all("ack", 4'd14, 1'b1, 1'b0, 1'b0);
    clk1(); clk1();
    chk_all("wrap2", 4'd12, 1'b1, 1'b1, 1'b1);

    // Mid-count write: new RLD used at the next wrap
    clk1(); chk("q13.Q", {28'd0, Q}, 32'd13);
    WR = 1'b1; D = 4'd8; clk1(); WR = 1'b0;
    chk("midwr.Q", {28'd0, Q}, 32'd14);
    clk1(); clk1();
    chk_all("wrap_new8", 4'd8, 1'b1, 1'b1, 1'b1);
    WR = 1'b1; D = 4'd14; clk1(); WR = 1'b0;
    chk("q9.Q", {28'd0, Q}, 32'd9);
    repeat (6) clk1();
    chk("q15.Q", {28'd0, Q}, 32'd15);
    // WR coincident with wrap: old RLD loaded
    WR = 1'b1; D = 4'd13; clk1(); WR = 1'b0;
    chk("wrwrap.Q", {28'd0, Q}, 32'd14);
    chk("wrwrap.TC", {31'd0, TC}, 32'd1);
    clk1(); clk1();
    chk("wrap_new13.Q", {28'd0, Q}, 32'd13);
    chk("wrap_new13.TC", {31'd0, TC}, 32'd1);

    // ACK on the same edge as a wrap leaves INT set
    ACK = 1'b1; clk1();
    chk("ack_clr.INT", {31'd0, INT}, 32'd0);
    clk1();
    chk("ack15.Q", {28'd0, Q}, 32'd15);
    clk1(); ACK = 1'b0;
    chk_all("ack_wrap", 4'd13, 1'b1, 1'b1, 1'b1);

    // STOP holds Q
    TICK = 1'b0; STOP = 1'b1; clk1(); STOP = 1'b0;
    chk_all("stop", 4'd13, 1'b0, 1'b0, 1'b1);

    // Gated tick, RLD=14; TICK in the START cycle is ignored
    WR = 1'b1; D = 4'd14; clk1(); WR = 1'b0;
    START = 1'b1; TICK = 1'b1; clk1(); START = 1'b0;
    chk("gstart.Q", {28'd0, Q}, 32'd14);
    for (int c = 0; c < 6; c++) begin
      TICK = (c % 3 == 2);
      clk1();
      chk($sformatf("gated%0d.Q", c), {28'd0, Q}, {28'd0, gq[c]});
      chk($sformatf("gated%0d.TC", c), {31'd0, TC}, {31'd0, gtc[c]});
    end

    // Maximum rate: RLD=15 gives TC every tick
    TICK = 1'b0; WR = 1'b1; D = 4'd15; clk1(); WR = 1'b0;
    START = 1'b1; clk1(); START = 1'b0;
    chk("max_start.Q", {28'd0, Q}, 32'd15);
    TICK = 1'b1;
    for (int c = 0; c < 3; c++) begin
      clk1();
      chk($sformatf("max%0d.TC", c), {31'd0, TC}, 32'd1);
      chk($sformatf("max%0d.Q", c), {28'd0, Q}, 32'd15);
    end

    // START+STOP: STOP wins; IDLE ignores TICK
    TICK = 1'b0; START = 1'b1; STOP = 1'b1; clk1(); START = 1'b0; STOP = 1'b0;
    chk("startstop.RUN", {31'd0, RUN}, 32'd0);
    TICK = 1'b1; clk1(); TICK = 1'b0;
    chk_all("idle_tick", 4'd15, 1'b0, 1'b0, 1'b1);

`ifdef TIMER_ONESHOT_EN
    WR = 1'b1; D = 4'd13; clk1(); WR = 1'b0;
    ONESHOT = 1'b1; START = 1'b1; clk1(); START = 1'b0;
    chk("os_start.RUN", {31'd0, RUN}, 32'd1);
    TICK = 1'b1;
    clk1(); clk1();
    chk("os15.Q", {28'd0, Q}, 32'd15);
    clk1();
    chk("os_wrap.TC", {31'd0, TC}, 32'd1);
    chk("os_wrap.RUN", {31'd0, RUN}, 32'd0);
    chk("os_wrap.Q", {28'd0, Q}, 32'd13);
    clk1(); clk1();
    chk("os_hold.TC", {31'd0, TC}, 32'd0);
    chk("os_hold.Q", {28'd0, Q}, 32'd13);
    TICK = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
